// File: rtl/ttt_board_ctrl_pkg.sv
// rtl/ttt_board_ctrl_pkg.sv - shared types, win-line masks and move legality for the tic-tac-toe controller
package ttt_pkg;

  // bit i = cell i, row-major, cell 4 is the centre
  typedef logic [8:0] board_t;

  typedef enum logic [2:0] {
    WAIT_X,
    EVAL_X,
    REQ_O,
    EVAL_O,
    DONE
  } state_t;

  // rows, columns, then the two diagonals
  localparam board_t WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1c0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  // a move must name exactly one cell and that cell must be empty
  function automatic logic is_legal(board_t mv, board_t occ);
    logic one_hot;
    one_hot = (mv != '0) && ((mv & (mv - 9'd1)) == '0);
    return one_hot && ((mv & occ) == '0);
  endfunction

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// rtl/ttt_board_ctrl_if.sv - move handshake bundle between the move sources and the board controller
interface ttt_board_ctrl_if;
  import ttt_pkg::*;

  board_t xin;
  logic   xin_valid;
  logic   xin_ready;
  board_t occupied;
  logic   comp_req;
  board_t comp_move;
  logic   comp_ack;

  // master: human input plus computer-move chooser
  modport master (
    output xin, xin_valid, comp_move, comp_ack,
    input  xin_ready, occupied, comp_req
  );

  // slave: the board controller
  modport slave (
    input  xin, xin_valid, comp_move, comp_ack,
    output xin_ready, occupied, comp_req
  );

endinterface

// File: rtl/ttt_board_ctrl_line_detect.sv
// rtl/ttt_board_ctrl_line_detect.sv - flags a board holding any complete row, column or diagonal
module ttt_line_detect
  import ttt_pkg::*;
(
  input  board_t board,
  output logic   win
);

  // OR of all eight line matches
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// rtl/ttt_board_ctrl.sv - tic-tac-toe board controller; TTT_COMP_FIRST_EN makes the computer open each game
module ttt_board_ctrl
  import ttt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game,
  ttt_board_ctrl_if.slave   mv,
  output board_t            xboard,
  output board_t            oboard,
  output logic              illegal,
  output logic              win_x,
  output logic              win_o,
  output logic              draw,
  output logic [3:0]        move_count
);

`ifdef TTT_COMP_FIRST_EN
  localparam state_t START_STATE = REQ_O;
  localparam logic   START_XRDY  = 1'b0;
`else
  localparam state_t START_STATE = WAIT_X;
  localparam logic   START_XRDY  = 1'b1;
`endif

  state_t state;
  logic   x_line;
  logic   o_line;
  logic   x_ok;
  logic   o_ok;

  ttt_line_detect u_x_line (.board(xboard), .win(x_line));
  ttt_line_detect u_o_line (.board(oboard), .win(o_line));

  // legality is judged against the registered occupied vector
  assign x_ok = is_legal(mv.xin, mv.occupied);
  assign o_ok = is_legal(mv.comp_move, mv.occupied);

  // game FSM; xin_ready and comp_req are registered so each rises one cycle after entering its wait state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= START_STATE;
      xboard       <= '0;
      oboard       <= '0;
      mv.occupied  <= '0;
      move_count   <= '0;
      mv.xin_ready <= START_XRDY;
      mv.comp_req  <= 1'b0;
      illegal      <= 1'b0;
      win_x        <= 1'b0;
      win_o        <= 1'b0;
      draw         <= 1'b0;
    end else if (new_game) begin
      state        <= START_STATE;
      xboard       <= '0;
      oboard       <= '0;
      mv.occupied  <= '0;
      move_count   <= '0;
      mv.xin_ready <= START_XRDY;
      mv.comp_req  <= 1'b0;
      illegal      <= 1'b0;
      win_x        <= 1'b0;
      win_o        <= 1'b0;
      draw         <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        WAIT_X: begin
          if (mv.xin_ready && mv.xin_valid) begin
            if (x_ok) begin
              xboard       <= xboard | mv.xin;
              mv.occupied  <= mv.occupied | mv.xin;
              move_count   <= move_count + 4'd1;
              mv.xin_ready <= 1'b0;
              state        <= EVAL_X;
            end else begin
              illegal <= 1'b1;
            end
          end else begin
            mv.xin_ready <= 1'b1;
          end
        end
        EVAL_X: begin
          if (x_line) begin
            win_x <= 1'b1;
            state <= DONE;
          end else if (move_count == 4'd9) begin
            draw  <= 1'b1;
            state <= DONE;
          end else begin
            state <= REQ_O;
          end
        end
        REQ_O: begin
          if (mv.comp_req && mv.comp_ack) begin
            if (o_ok) begin
              oboard      <= oboard | mv.comp_move;
              mv.occupied <= mv.occupied | mv.comp_move;
              move_count  <= move_count + 4'd1;
              mv.comp_req <= 1'b0;
              state       <= EVAL_O;
            end else begin
              illegal <= 1'b1;
            end
          end else begin
            mv.comp_req <= 1'b1;
          end
        end
        EVAL_O: begin
          if (o_line) begin
            win_o <= 1'b1;
            state <= DONE;
          end else if (move_count == 4'd9) begin
            draw  <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAIT_X;
          end
        end
        DONE: begin
          mv.xin_ready <= 1'b0;
          mv.comp_req  <= 1'b0;
        end
        default: state <= START_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb/tb_ttt_board_ctrl.sv - randomized scoreboard bench for ttt_board_ctrl (honours TTT_COMP_FIRST_EN)
module tb_ttt_board_ctrl;
  import ttt_pkg::*;

`ifdef TTT_COMP_FIRST_EN
  localparam bit COMP_FIRST = 1'b1;
`else
  localparam bit COMP_FIRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  board_t     xboard, oboard;
  logic       illegal, win_x, win_o, draw;
  logic [3:0] move_count;

  ttt_board_ctrl_if bus ();

  ttt_board_ctrl dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .mv(bus),
    .xboard(xboard), .oboard(oboard), .illegal(illegal),
    .win_x(win_x), .win_o(win_o), .draw(draw), .move_count(move_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ill;
    logic [8:0] x;
    logic [8:0] o;
    int         cnt;
  } step_t;

  step_t      step_q[$];
  logic [2:0] res_q[$];
  logic [8:0] xs[$];
  logic [8:0] os[$];
  int         checks = 0;
  int         fails = 0;
  logic [8:0] mx = '0, mo = '0;
  int         mcnt = 0;
  bit         over = 0;
  bit         mon_en = 0;
  logic [8:0] prev_x = '0, prev_o = '0;
  logic [2:0] prev_res = '0;

  // ---------------- reference model (grid rules, plain arithmetic) ----------------
  function automatic bit has_line(logic [8:0] b);
    for (int k = 0; k < 3; k++) begin
      if (b[3*k] && b[3*k+1] && b[3*k+2]) return 1'b1;
      if (b[k] && b[k+3] && b[k+6]) return 1'b1;
    end
    return (b[0] && b[4] && b[8]) || (b[2] && b[4] && b[6]);
  endfunction

  function automatic bit legal_mv(logic [8:0] m);
    return ($countones(m) == 1) && ((m & (mx | mo)) == '0);
  endfunction

  task automatic model_move(input bit is_x, input logic [8:0] m);
    if (!legal_mv(m)) begin
      step_q.push_back('{1'b1, mx, mo, mcnt});
      return;
    end
    if (is_x) mx = mx | m; else mo = mo | m;
    mcnt++;
    step_q.push_back('{1'b0, mx, mo, mcnt});
    if (has_line(is_x ? mx : mo)) begin
      res_q.push_back(is_x ? 3'b100 : 3'b010);
      over = 1;
    end else if (mcnt == 9) begin
      res_q.push_back(3'b001);
      over = 1;
    end
  endtask

  task automatic model_clear();
    if ((mx | mo) != '0) step_q.push_back('{1'b0, 9'h000, 9'h000, 0});
    mx = '0; mo = '0; mcnt = 0; over = 0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every board change or illegal pulse pops a step, every result rise pops a result
  always @(negedge clk) begin
    step_t e;
    logic [2:0] res;
    if (mon_en) begin
      if (illegal || xboard !== prev_x || oboard !== prev_o) begin
        checks++;
        if (step_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: ill=%0b x=%03h o=%03h", illegal, xboard, oboard);
        end else begin
          e = step_q.pop_front();
          if (illegal !== e.ill || xboard !== e.x || oboard !== e.o ||
              move_count !== 4'(e.cnt) || bus.occupied !== (e.x | e.o)) begin
            fails++;
            $display("FAIL step: got ill=%0b x=%03h o=%03h cnt=%0d occ=%03h expected ill=%0b x=%03h o=%03h cnt=%0d",
                     illegal, xboard, oboard, move_count, bus.occupied, e.ill, e.x, e.o, e.cnt);
          end
        end
      end
      res = {win_x, win_o, draw};
      if (res !== prev_res && res != 3'b000) begin
        checks++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got %03b", res);
        end else if (res !== res_q[0]) begin
          fails++;
          $display("FAIL result: got win_x,win_o,draw=%03b expected %03b", res, res_q[0]);
          void'(res_q.pop_front());
        end else begin
          void'(res_q.pop_front());
        end
      end
      prev_x = xboard; prev_o = oboard; prev_res = res;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pick(input bit is_x, input bit force_legal, output logic [8:0] m);
    logic [8:0] occ;
    logic [8:0] pool;
    int n;
    occ = mx | mo;
    if (!force_legal && is_x && xs.size() > 0) begin m = xs.pop_front(); return; end
    if (!force_legal && !is_x && os.size() > 0) begin m = os.pop_front(); return; end
    pool = ~occ;
    if (!force_legal && $urandom_range(3) == 0) begin
      case ($urandom_range(2))
        0: begin m = 9'h003 << $urandom_range(7); return; end
        1: begin m = '0; return; end
        default: if (occ != '0) pool = occ; else begin m = '0; return; end
      endcase
    end
    n = int'($urandom_range($countones(pool) - 1));
    m = '0;
    for (int i = 0; i < 9; i++) begin
      if (pool[i]) begin
        if (n == 0) begin m = 9'h001 << i; return; end
        n--;
      end
    end
  endtask

  task automatic wait_hi(input bit sel, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if ((sel ? bus.comp_req : bus.xin_ready) === 1'b1) begin ok = 1; return; end
      @(negedge clk);
    end
    checks++; fails++;
    $display("FAIL timeout_%s: still low after 20 cycles, required high", sel ? "comp_req" : "xin_ready");
  endtask

  // called on the first negedge after the accepting edge; counts further edges until the handshake rises
  task automatic latency(input bit sel, input string nm);
    int lat;
    lat = 0;
    while ((sel ? bus.comp_req : bus.xin_ready) !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, lat, 2);
  endtask

  task automatic x_turn(output bit ok);
    logic [8:0] m;
    bit acc;
    acc = 0; ok = 1;
    while (!acc) begin
      wait_hi(1'b0, ok);
      if (!ok) return;
      pick(1'b1, 1'b0, m);
      acc = legal_mv(m);
      model_move(1'b1, m);
      bus.xin = m; bus.xin_valid = 1'b1;
      @(negedge clk);
      bus.xin_valid = 1'b0; bus.xin = 9'($urandom);
      if (!acc) chk("xin_ready_after_illegal", 32'(bus.xin_ready), 1);
    end
    if (!over) latency(1'b1, "lat_accept_to_comp_req");
  endtask

  task automatic o_turn(output bit ok, input int abort);
    logic [8:0] m;
    bit acc;
    acc = 0; ok = 1;
    wait_hi(1'b1, ok);
    if (!ok) return;
    if (abort == 1) begin
      pick(1'b0, 1'b1, m);
      model_clear();
      bus.comp_move = m; bus.comp_ack = 1'b1; new_game = 1'b1;
      @(negedge clk);
      bus.comp_ack = 1'b0; new_game = 1'b0;
      chk("xin_ready_after_ng_ack", 32'(bus.xin_ready), 32'(!COMP_FIRST));
      chk("comp_req_after_ng_ack", 32'(bus.comp_req), 0);
      return;
    end
    if (abort == 2) begin
      pick(1'b0, 1'b1, m);
      model_clear();
      bus.comp_move = m; bus.comp_ack = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      bus.comp_ack = 1'b0; rst_n = 1'b1;
      chk("move_count_after_rst", 32'(move_count), 0);
      chk("xin_ready_after_rst", 32'(bus.xin_ready), 32'(!COMP_FIRST));
      return;
    end
    while (!acc) begin
      pick(1'b0, 1'b0, m);
      acc = legal_mv(m);
      model_move(1'b0, m);
      bus.comp_move = m; bus.comp_ack = 1'b1;
      @(negedge clk);
      bus.comp_ack = 1'b0;
      if (!acc) chk("comp_req_after_illegal", 32'(bus.comp_req), 1);
    end
    if (!over) latency(1'b0, "lat_ack_to_xin_ready");
  endtask

  task automatic do_new_game();
    model_clear();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("xin_ready_after_new_game", 32'(bus.xin_ready), 32'(!COMP_FIRST));
    chk("flags_after_new_game", 32'({win_x, win_o, draw, illegal}), 0);
  endtask

  // mode 0: play to the end; 1: new_game + ack at first computer turn; 2: async reset at first computer turn
  task automatic play_game(input int mode);
    bit ok, xturn;
    ok = 1;
    xturn = !COMP_FIRST;
    while (!over && ok) begin
      if (xturn) x_turn(ok);
      else begin
        o_turn(ok, mode);
        if (mode != 0) return;
      end
      xturn = !xturn;
    end
    if (over) begin
      @(negedge clk);
      chk("xin_ready_in_done", 32'(bus.xin_ready), 0);
      chk("comp_req_in_done", 32'(bus.comp_req), 0);
      for (int i = 0; i < 3; i++) begin
        bus.xin = 9'h001 << $urandom_range(8); bus.xin_valid = 1'b1;
        bus.comp_move = 9'h001 << $urandom_range(8); bus.comp_ack = 1'b1;
        @(negedge clk);
      end
      bus.xin_valid = 1'b0; bus.comp_ack = 1'b0;
      chk("comp_req_stays_low_in_done", 32'(bus.comp_req), 0);
    end
    do_new_game();
  endtask

  initial begin
    bus.xin = '0; bus.xin_valid = 1'b0; bus.comp_move = '0; bus.comp_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_boards", 32'({xboard, oboard}), 0);
    chk("reset_occupied", 32'(bus.occupied), 0);
    chk("reset_count", 32'(move_count), 0);
    chk("reset_flags", 32'({illegal, win_x, win_o, draw, bus.comp_req}), 0);
    chk("reset_xin_ready", 32'(bus.xin_ready), 32'(!COMP_FIRST));
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    if (COMP_FIRST) begin
      chk("comp_first_comp_req", 32'(bus.comp_req), 1);
      chk("comp_first_xin_ready", 32'(bus.xin_ready), 0);
    end else begin
      // opening, occupied and two-bit rejects, then random finish
      xs = '{9'h010, 9'h010, 9'h011}; os = '{9'h001};
      play_game(0);
      // O tries an occupied cell, X wins on diagonal 0-4-8
      xs = '{9'h001, 9'h010, 9'h100}; os = '{9'h001, 9'h002, 9'h004};
      play_game(0);
      // full board, no line: draw
      xs = '{9'h001, 9'h002, 9'h020, 9'h040, 9'h100}; os = '{9'h004, 9'h008, 9'h010, 9'h080};
      play_game(0);
      // ninth cell completes column 2-5-8: win beats draw
      xs = '{9'h001, 9'h004, 9'h020, 9'h080, 9'h100}; os = '{9'h002, 9'h008, 9'h010, 9'h040};
      play_game(0);
    end
    for (int g = 0; g < 40; g++) play_game(g == 3 ? 1 : (g == 7 ? 2 : 0));
    repeat (3) @(negedge clk);
    chk("step_queue_drained", step_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
